// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch stage of the 5-stage MIPS pipeline.
package cpu_types_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    // FETCH: normal fetch; REDIR_PEND: old request outstanding, target parked;
    // HALTED: fetch stopped until reset.
    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: holds the fetched instruction, its PC+4 and a valid bit.
// Ports: i_clk/i_nrst clock and async active-low reset; i_en loads i_instr/i_npc
// as a valid entry; i_flush loads a nop bubble (dominates i_en); neither = hold.
module if_id_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_npc,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_npc,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_npc;
    logic              r_valid;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_instr <= WORD_W'(NOP_INSTR);
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= WORD_W'(NOP_INSTR);
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, parked redirect target, fetch FSM and
// the IF/ID latch feeding decode.
// Ports: CLK/nRST clock and async active-low reset; stall, freeze, redirect
// (+redirect_pc), halt control inputs; ihit/imemload instruction memory reply;
// imemREN/imemaddr combinational memory request; IF_*_OUT the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned       WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              stall,
    input  logic              freeze,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] IF_Instr_OUT,
    output logic [WORD_W-1:0] IF_npc_OUT,
    output logic              IF_valid_OUT
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_next;
    logic [WORD_W-1:0] r_pend_pc;
    logic [WORD_W-1:0] w_pend_next;
    logic [WORD_W-1:0] w_pc_plus4;
    logic              w_ifid_en;
    logic              w_ifid_flush;

    // State, PC and parked redirect target.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= FETCH;
            r_pc      <= PC_INIT;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_next;
        end
    end

    assign w_pc_plus4 = r_pc + WORD_W'(WORD_BYTES);

    // Next state / next PC; priority halt > freeze > redirect > stall > normal.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pend_next  = r_pend_pc;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;

        if (halt) begin
            w_state_next = HALTED;
            w_ifid_flush = 1'b1;
        end else if (r_state == HALTED) begin
            w_state_next = HALTED;
        end else if (freeze) begin
            // Old request may still be in flight, so a redirect is only parked.
            if (redirect) begin
                w_pend_next  = redirect_pc;
                w_state_next = REDIR_PEND;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect) begin
                        w_ifid_flush = 1'b1;
                        if (ihit) begin
                            w_pc_next = redirect_pc;
                        end else begin
                            w_pend_next  = redirect_pc;
                            w_state_next = REDIR_PEND;
                        end
                    end else if (!stall) begin
                        if (ihit) begin
                            w_pc_next = w_pc_plus4;
                            w_ifid_en = 1'b1;
                        end else begin
                            w_ifid_flush = 1'b1;
                        end
                    end
                end
                REDIR_PEND: begin
                    // Returned word belongs to the squashed path; newest target wins.
                    w_ifid_flush = 1'b1;
                    if (ihit) begin
                        w_pc_next    = redirect ? redirect_pc : r_pend_pc;
                        w_state_next = FETCH;
                    end else if (redirect) begin
                        w_pend_next = redirect_pc;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    assign imemaddr = r_pc;
    assign imemREN  = (r_state != HALTED);

    if_id_reg #(
        .WORD_W (WORD_W)
    ) u_if_id (
        .i_clk   (CLK),
        .i_nrst  (nRST),
        .i_en    (w_ifid_en),
        .i_flush (w_ifid_flush),
        .i_instr (imemload),
        .i_npc   (w_pc_plus4),
        .o_instr (IF_Instr_OUT),
        .o_npc   (IF_npc_OUT),
        .o_valid (IF_valid_OUT)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives the instruction memory request, and holds the IF/ID pipeline latch that the decode stage and the hazard unit read. It honours the load-use stall from the hazard unit, a pipeline-wide freeze, branch/jump redirects from the execute stage, and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction and address width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
stall  in  1  load-use stall from the hazard unit; hold PC and IF/ID
freeze  in  1  pipeline-wide hold (data memory busy); hold all state
redirect  in  1  taken branch or jump resolved in EX; single-cycle pulse
redirect_pc  in  WORD_W  target PC, valid when redirect=1
halt  in  1  halt decoded downstream; stop fetching permanently
ihit  in  1  instruction memory returns imemload this cycle
imemload  in  WORD_W  instruction data
imemREN  out  1  instruction read enable
imemaddr  out  WORD_W  instruction address (equals PC)
IF_Instr_OUT  out  WORD_W  latched instruction to decode
IF_npc_OUT  out  WORD_W  latched PC+4 of that instruction
IF_valid_OUT  out  1  latched instruction is real (0 = bubble)

Behaviour:
- Reset (nRST=0, async): PC=PC_INIT, pend_pc=0, state=FETCH, IF_Instr_OUT=0 (nop), IF_npc_OUT=0, IF_valid_OUT=0.
- States: FETCH, REDIR_PEND, HALTED.
- imemaddr=PC at all times. imemREN=1 in FETCH and REDIR_PEND, 0 in HALTED. Both are combinational from state.
- Priority each cycle: halt > freeze > redirect > stall > normal.
- halt=1 (any state): next state HALTED, IF/ID <= nop/valid 0, PC held. HALTED exits only on reset.
- freeze=1: PC, IF/ID and state hold. If redirect=1 in the same cycle: pend_pc <= redirect_pc, state <= REDIR_PEND.
- FETCH, redirect=1, ihit=1: PC <= redirect_pc, IF/ID <= nop/valid 0. The redirect flushes IF/ID even if stall=1.
- FETCH, redirect=1, ihit=0: the request to the old PC is outstanding. pend_pc <= redirect_pc, state <= REDIR_PEND, IF/ID <= nop/valid 0.
- FETCH, no redirect, ihit=1, stall=0: PC <= PC+4 (mod 2^32, wraps silently). IF_Instr_OUT <= imemload, IF_npc_OUT <= PC+4, IF_valid_OUT <= 1.
- FETCH, ihit=1, stall=1: PC and IF/ID hold. The same fetch repeats next cycle.
- FETCH, ihit=0, stall=0: PC holds. IF/ID <= nop/valid 0 (bubble).
- FETCH, ihit=0, stall=1: PC and IF/ID hold.
- REDIR_PEND: imemaddr stays at the old PC until ihit.
  - On ihit=1: the returned data is discarded, PC <= pend_pc, state <= FETCH, IF/ID stays nop.
  - A further redirect in REDIR_PEND overwrites pend_pc (newest wins).
  - stall has no effect in REDIR_PEND. IF/ID is held at nop.
- Latency: an instruction at PC with ihit in cycle n appears on IF_Instr_OUT in cycle n+1.
- Redirect penalty: the target is requested in cycle n+1 after redirect when ihit was present in cycle n; otherwise it is requested in the cycle after the outstanding ihit.
- PC+4 is a WORD_W-bit add; carry is dropped. PC bits [1:0] are not checked and pass through unchanged.

Decomposition:
- Shared package (cpu_types_pkg): fetch_state_t enum {FETCH, REDIR_PEND, HALTED}, NOP_INSTR = 32'h0, WORD_BYTES = 4.
- One sub-module, if_id_reg: the IF/ID latch with async reset, hold (en=0), flush (load nop/valid 0), and load inputs.
- fetch_stage contains the PC register, pend_pc, the FSM and the next-state/next-PC logic.

Test Plan:
- Reset, then ihit=1 every cycle with imemload=PC-derived values: imemaddr steps 0x0, 0x4, 0x8. IF_Instr_OUT lags by 1 cycle, IF_npc_OUT=0x4, 0x8, IF_valid=1.
- stall=1 for 2 cycles at PC=0x8 with ihit=1: imemaddr stays 0x8 and IF/ID holds the 0x4 instruction. On release, PC advances to 0xC.
- FETCH, ihit=1, redirect=1, redirect_pc=0x100, stall=1: next cycle imemaddr=0x100 and IF_valid_OUT=0.
- ihit=0 at PC=0x20 with redirect=1, redirect_pc=0x200; second redirect to 0x300 two cycles later; ihit=1 after 3 more cycles:
  - imemaddr stays 0x20 until that ihit, then becomes 0x300.
  - The returned word never reaches IF/ID.
- freeze=1 for 3 cycles with ihit=1 and redirect to 0x40 during freeze:
  - All outputs hold during freeze.
  - After freeze drops, imemaddr=0x40 following the next ihit.
- halt=1 at PC=0x50: imemREN=0 and IF_valid_OUT=0 the next cycle and thereafter. Async nRST pulse mid-cycle restores PC_INIT and FETCH immediately.
